dataram_arbiter: RTL and testbench

Two-requester arbiter for the single data-RAM port. It sits between the pipelined core's MEM-stage memory outputs (`ena_rd`, `ena_wr`, `alu_out_ext`, `dataram_wr`) and the RAM. It shares that port with an external requester (program loader / debug master) using a valid/ready handshake. The core has priority. A starvation counter guarantees the external requester service: when the limit is reached, the arbiter freezes the core for one cycle and grants the port to the external requester.

---
 rtl/dataram_arbiter.sv | 118 +++++++++++
 tb/tb_dataram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dataram_arbiter.sv
// Arbitrates the single data-RAM port between the core MEM stage (priority) and an
// external valid/ready requester, forcing a one-cycle core freeze when the external side starves.
module dataram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        core_ena_rd,
  input  logic        core_ena_wr,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_hold,
  input  logic        ext_valid,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ready,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        ram_ena_rd,
  output logic        ram_ena_wr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [15:0] force_cnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic            r_core_hold;
  logic            r_ext_rvalid;
  logic [31:0]     r_ext_rdata;
  logic [15:0]     r_force_cnt;
  logic            w_core_busy;
  logic            w_in_force;

  assign w_core_busy = core_ena_rd | core_ena_wr;
  assign w_in_force  = (r_state == S_FORCE);
  assign ext_ready   = ext_valid && (w_in_force || !w_core_busy);
  assign core_rdata  = ram_rdata;
  assign core_hold   = r_core_hold;
  assign ext_rvalid  = r_ext_rvalid;
  assign ext_rdata   = r_ext_rdata;
  assign force_cnt   = r_force_cnt;

  // The frozen core re-presents its access next cycle, so its enables are dropped in FORCE.
  always_comb begin
    ram_ena_rd = core_ena_rd & ~w_in_force;
    ram_ena_wr = core_ena_wr & ~w_in_force;
    ram_addr   = core_addr;
    ram_wdata  = core_wdata;
    if (ext_ready) begin
      ram_ena_rd = ~ext_we;
      ram_ena_wr = ext_we;
      ram_addr   = ext_addr;
      ram_wdata  = ext_wdata;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (ext_valid && w_core_busy) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = CW'(1);
        end
      end
      S_WAIT: begin
        if (!ext_valid || ext_ready) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == CW'(STARVE_MAX)) begin
          w_state_nxt = S_FORCE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CW'(1);
        end
      end
      S_FORCE: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_core_hold  <= 1'b0;
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
      r_force_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_core_hold  <= (w_state_nxt == S_FORCE);
      r_ext_rvalid <= ext_ready && !ext_we;
      if (ext_ready && !ext_we) begin
        r_ext_rdata <= ram_rdata;
      end
      if ((w_state_nxt == S_FORCE) && !w_in_force && (r_force_cnt != 16'hFFFF)) begin
        r_force_cnt <= r_force_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dataram_arbiter.sv
// Bench for dataram_arbiter: scenario tasks with a read-data scoreboard, plus a
// second STARVE_MAX=1 instance left permanently starving to reach force_cnt saturation.
module tb_dataram_arbiter;

  logic        CLOCK = 1'b0;
  logic        RST_n = 1'b0;
  logic        core_ena_rd = 1'b0, core_ena_wr = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_hold;
  logic        ext_valid = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ram_ena_rd, ram_ena_wr;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [15:0] force_cnt;

  logic        sat_rst_n = 1'b0;
  logic [31:0] s_core_rdata, s_ext_rdata, s_ram_addr, s_ram_wdata;
  logic        s_core_hold, s_ext_ready, s_ext_rvalid, s_ram_ena_rd, s_ram_ena_wr;
  logic [15:0] s_force_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ~a;
  endfunction

  assign ram_rdata = ram_model(ram_addr);

  dataram_arbiter #(.STARVE_MAX(4)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n),
    .core_ena_rd(core_ena_rd), .core_ena_wr(core_ena_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_hold(core_hold),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_ena_rd(ram_ena_rd), .ram_ena_wr(ram_ena_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .force_cnt(force_cnt)
  );

  dataram_arbiter #(.STARVE_MAX(1)) u_sat (
    .CLOCK(CLOCK), .RST_n(sat_rst_n),
    .core_ena_rd(1'b0), .core_ena_wr(1'b1),
    .core_addr(32'h20), .core_wdata(32'h0),
    .core_rdata(s_core_rdata), .core_hold(s_core_hold),
    .ext_valid(1'b1), .ext_we(1'b1), .ext_addr(32'h40), .ext_wdata(32'h55),
    .ext_ready(s_ext_ready), .ext_rvalid(s_ext_rvalid), .ext_rdata(s_ext_rdata),
    .ram_ena_rd(s_ram_ena_rd), .ram_ena_wr(s_ram_ena_wr),
    .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(32'h0),
    .force_cnt(s_force_cnt)
  );

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    core_ena_rd = 0; core_ena_wr = 0; ext_valid = 0; ext_we = 0;
  endtask

  task automatic test_reset();
    RST_n = 0;
    core_ena_rd = 1; core_addr = 32'h30;
    #3;
    total++; if (core_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", core_hold); end
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin bad++; $display("FAIL reset_rvalid got=%b/%h exp=0/0", ext_rvalid, ext_rdata); end
    total++; if (force_cnt !== 16'h0) begin bad++; $display("FAIL reset_force_cnt got=%h exp=0", force_cnt); end
    total++; if (ram_ena_rd !== 1'b1 || ram_addr !== 32'h30 || core_rdata !== ~32'h30) begin bad++; $display("FAIL reset_passthru got=%b/%h/%h", ram_ena_rd, ram_addr, core_rdata); end
    core_ena_rd = 0; ext_valid = 1; ext_we = 1; ext_addr = 32'h8;
    #1;
    total++; if (ext_ready !== 1'b1 || ram_ena_wr !== 1'b1 || ram_addr !== 32'h8) begin bad++; $display("FAIL reset_idle_grant got=%b/%b/%h exp=1/1/8", ext_ready, ram_ena_wr, ram_addr); end
    idle_inputs();
    @(negedge CLOCK);
    RST_n = 1;
  endtask

  task automatic test_idle_read();
    tick();
    ext_valid = 1; ext_we = 0; ext_addr = 32'h10;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge CLOCK);
    total++; if (ext_ready !== 1'b1 || ram_ena_rd !== 1'b1 || ram_ena_wr !== 1'b0 || ram_addr !== 32'h10) begin bad++; $display("FAIL idle_read_grant got=%b/%b/%h", ext_ready, ram_ena_rd, ram_addr); end
    total++; if (core_hold !== 1'b0 || ext_rvalid !== 1'b0) begin bad++; $display("FAIL idle_read_early got=%b/%b exp=0/0", core_hold, ext_rvalid); end
    tick();
    ext_valid = 0;
    @(negedge CLOCK);
    total++;
    if (ext_rvalid !== 1'b1 || exp_q.size() == 0) begin bad++; $display("FAIL idle_read_rvalid got=%b exp=1", ext_rvalid); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (ext_rdata !== e) begin bad++; $display("FAIL idle_read_data got=%h exp=%h", ext_rdata, e); end
    end
    total++; if (core_hold !== 1'b0) begin bad++; $display("FAIL idle_read_hold got=%b exp=0", core_hold); end
    tick();
    @(negedge CLOCK);
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL idle_read_pulse got=%b exp=0", ext_rvalid); end
  endtask

  task automatic test_force_write(input logic [15:0] exp_fc);
    bit found = 0;
    tick();
    core_ena_wr = 1; core_addr = 32'h20; core_wdata = 32'h1234;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'h55;
    for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
      @(negedge CLOCK);
      if (ext_ready) begin
        found = 1;
        total++; if (cyc != 6) begin bad++; $display("FAIL force_cycle got=%0d exp=6", cyc); end
        total++; if (core_hold !== 1'b1 || ram_addr !== 32'h40 || ram_wdata !== 32'h55 || ram_ena_wr !== 1'b1 || ram_ena_rd !== 1'b0) begin
          bad++; $display("FAIL force_grant got=%b/%h/%h/%b/%b", core_hold, ram_addr, ram_wdata, ram_ena_wr, ram_ena_rd);
        end
        total++; if (force_cnt !== exp_fc) begin bad++; $display("FAIL force_cnt got=%h exp=%h", force_cnt, exp_fc); end
      end else begin
        total++; if (core_hold !== 1'b0 || ram_addr !== 32'h20 || ram_ena_wr !== 1'b1) begin bad++; $display("FAIL force_denied cyc=%0d got=%b/%h/%b", cyc, core_hold, ram_addr, ram_ena_wr); end
      end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL force_timeout got=no_grant exp=grant"); end
    ext_valid = 0;
    @(negedge CLOCK);
    total++; if (core_hold !== 1'b0 || ram_addr !== 32'h20 || ram_ena_wr !== 1'b1 || ram_wdata !== 32'h1234) begin bad++; $display("FAIL force_resume got=%b/%h/%b", core_hold, ram_addr, ram_ena_wr); end
    idle_inputs();
  endtask

  task automatic test_busy_then_idle();
    logic [15:0] fc0 = force_cnt;
    bit found = 0;
    tick();
    ext_valid = 1; ext_we = 0; ext_addr = 32'h44;
    for (int cyc = 1; cyc <= 10 && !found; cyc++) begin
      core_ena_rd = (cyc <= 2); core_addr = 32'h80;
      @(negedge CLOCK);
      if (ext_ready) begin
        found = 1;
        exp_q.push_back(ram_model(32'h44));
        total++; if (cyc != 3 || core_hold !== 1'b0 || ram_addr !== 32'h44) begin bad++; $display("FAIL busy_idle_grant cyc=%0d hold=%b addr=%h exp=3/0/44", cyc, core_hold, ram_addr); end
      end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL busy_idle_timeout got=no_grant exp=grant"); end
    ext_valid = 0; core_ena_rd = 0;
    @(negedge CLOCK);
    total++;
    if (ext_rvalid !== 1'b1 || exp_q.size() == 0) begin bad++; $display("FAIL busy_idle_rvalid got=%b exp=1", ext_rvalid); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (ext_rdata !== e) begin bad++; $display("FAIL busy_idle_data got=%h exp=%h", ext_rdata, e); end
    end
    total++; if (force_cnt !== fc0) begin bad++; $display("FAIL busy_idle_fc got=%h exp=%h", force_cnt, fc0); end
  endtask

  task automatic test_alternate();
    logic [31:0] reqs[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    int  idx = 0;
    bit  pend_rv = 0;
    tick();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      core_ena_wr = cyc[0]; core_addr = 32'h200 + cyc; core_wdata = cyc;
      ext_valid = (idx < 4); ext_we = 0; ext_addr = (idx < 4) ? reqs[idx] : 32'h0;
      @(negedge CLOCK);
      total++;
      if (ext_rvalid !== pend_rv) begin bad++; $display("FAIL alt_rvalid cyc=%0d got=%b exp=%b", cyc, ext_rvalid, pend_rv); end
      else if (pend_rv) begin
        logic [31:0] e = exp_q.pop_front();
        if (ext_rdata !== e) begin bad++; $display("FAIL alt_data cyc=%0d got=%h exp=%h", cyc, ext_rdata, e); end
      end
      pend_rv = 0;
      total++;
      if (cyc[0]) begin
        if (ext_ready !== 1'b0 || ram_ena_wr !== 1'b1 || ram_addr !== core_addr || ram_wdata !== core_wdata) begin
          bad++; $display("FAIL alt_core cyc=%0d got=%b/%b/%h", cyc, ext_ready, ram_ena_wr, ram_addr);
        end
      end else if (idx < 4) begin
        if (ext_ready !== 1'b1 || ram_ena_rd !== 1'b1 || ram_addr !== reqs[idx]) begin
          bad++; $display("FAIL alt_ext cyc=%0d got=%b/%b/%h exp=1/1/%h", cyc, ext_ready, ram_ena_rd, ram_addr, reqs[idx]);
        end else begin
          exp_q.push_back(ram_model(reqs[idx]));
          pend_rv = 1;
          idx++;
        end
      end else if (ext_ready !== 1'b0 || ram_ena_rd !== 1'b0 || ram_ena_wr !== 1'b0) begin
        bad++; $display("FAIL alt_quiet cyc=%0d got=%b/%b/%b", cyc, ext_ready, ram_ena_rd, ram_ena_wr);
      end
      total++; if (core_hold !== 1'b0) begin bad++; $display("FAIL alt_hold cyc=%0d got=%b exp=0", cyc, core_hold); end
      tick();
    end
    total++; if (idx != 4 || exp_q.size() != 0) begin bad++; $display("FAIL alt_served got=%0d/%0d exp=4/0", idx, exp_q.size()); end
    idle_inputs();
  endtask

  task automatic test_reset_in_force();
    bit found = 0;
    tick();
    core_ena_wr = 1; core_addr = 32'h20;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h60;
    for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
      @(negedge CLOCK);
      if (core_hold) found = 1; else tick();
    end
    total++; if (!found || force_cnt === 16'h0) begin bad++; $display("FAIL rst_force_reach got=%b/%h exp=1/nonzero", found, force_cnt); end
    #1 RST_n = 0;
    #1;
    total++; if (core_hold !== 1'b0 || ext_rvalid !== 1'b0 || force_cnt !== 16'h0) begin bad++; $display("FAIL rst_force_async got=%b/%b/%h exp=0/0/0", core_hold, ext_rvalid, force_cnt); end
    total++; if (ext_ready !== 1'b0 || ram_addr !== 32'h20) begin bad++; $display("FAIL rst_force_port got=%b/%h exp=0/20", ext_ready, ram_addr); end
    tick();
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin bad++; $display("FAIL rst_force_drop got=%b/%h exp=0/0", ext_rvalid, ext_rdata); end
    idle_inputs();
    @(negedge CLOCK);
    RST_n = 1;
  endtask

  task automatic test_saturate();
    int pulses = 0;
    @(negedge CLOCK);
    sat_rst_n = 1;
    for (int cyc = 0; cyc < 200000 && pulses < 65537; cyc++) begin
      @(negedge CLOCK);
      if (s_core_hold) begin
        pulses++;
        if (pulses == 1 || pulses == 65535 || pulses == 65537) begin
          logic [15:0] e = (pulses >= 65535) ? 16'hFFFF : 16'(pulses);
          total++; if (s_force_cnt !== e) begin bad++; $display("FAIL sat_cnt pulses=%0d got=%h exp=%h", pulses, s_force_cnt, e); end
        end
      end
    end
    total++; if (pulses != 65537) begin bad++; $display("FAIL sat_timeout got=%0d exp=65537", pulses); end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_force_write(16'd1);
    test_busy_then_idle();
    test_force_write(16'd2);
    test_alternate();
    test_reset_in_force();
    test_force_write(16'd1);
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
